// File: rtl/vram_term.sv
// Terminal write engine: turns ASCII characters into 6-bit VRAM writes,
// tracking a 40x24 cursor with wrap, carriage return and row-rotation scrolling.
module vram_term #(
    parameter int unsigned COLS  = 40,
    parameter int unsigned ROWS  = 24,
    parameter logic [5:0]  BLANK = 6'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        clr_screen,
    output logic [10:0] vram_waddr,
    output logic [5:0]  vram_din,
    output logic        vram_wen,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic [4:0]  top_row
);

    localparam int unsigned CELLS = ROWS * COLS;

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

    state_t     state;
    logic [9:0] clr_addr;
    logic [5:0] clr_col;

    logic       is_cr;
    logic       is_print;
    logic [5:0] char_code;
    logic [4:0] bottom_row;

    // Linear cell address; row*40 built from shifts to avoid a multiplier.
    function automatic logic [10:0] addr_of(input logic [4:0] row, input logic [5:0] col);
        return ({6'd0, row} << 5) + ({6'd0, row} << 3) + {5'd0, col};
    endfunction

    function automatic logic [4:0] row_inc(input logic [4:0] row);
        return (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
    endfunction

    assign char_ready = (state == IDLE) && !clr_screen;
    assign is_cr      = (char_in == 7'h0D);
    assign is_print   = |char_in[6:5];
    // Lowercase 0x60..0x7F folds onto 0x40..0x5F.
    assign char_code  = char_in[5:0] - ((char_in[6] & char_in[5]) ? 6'h20 : 6'h00);
    assign bottom_row = (top_row == 5'd0) ? 5'(ROWS - 1) : top_row - 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLR_ALL;
            clr_addr   <= '0;
            clr_col    <= '0;
            vram_wen   <= 1'b0;
            vram_waddr <= '0;
            vram_din   <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            top_row    <= '0;
        end else begin
            vram_wen <= 1'b0;
            case (state)
                CLR_ALL: begin
                    // One idle cycle after the last write keeps char_ready low until it lands.
                    if (clr_addr == 10'(CELLS)) begin
                        state <= IDLE;
                    end else begin
                        vram_wen   <= 1'b1;
                        vram_waddr <= 11'(clr_addr);
                        vram_din   <= BLANK;
                        clr_addr   <= clr_addr + 10'd1;
                    end
                end

                IDLE: begin
                    if (clr_screen) begin
                        state      <= CLR_ALL;
                        clr_addr   <= '0;
                        cursor_col <= '0;
                        cursor_row <= '0;
                        top_row    <= '0;
                    end else if (char_valid) begin
                        if (is_print) begin
                            vram_wen   <= 1'b1;
                            vram_waddr <= addr_of(cursor_row, cursor_col);
                            vram_din   <= char_code;
                        end
                        if (is_print && cursor_col != 6'(COLS - 1)) begin
                            cursor_col <= cursor_col + 6'd1;
                        end else if (is_print || is_cr) begin
                            cursor_col <= '0;
                            if (cursor_row != bottom_row) begin
                                cursor_row <= row_inc(cursor_row);
                            end else begin
                                // Scroll: reuse the oldest row as the new bottom line.
                                cursor_row <= top_row;
                                state      <= CLR_LINE;
                                if (is_cr) begin
                                    vram_wen   <= 1'b1;
                                    vram_waddr <= addr_of(top_row, 6'd0);
                                    vram_din   <= BLANK;
                                    clr_col    <= 6'd1;
                                end else begin
                                    clr_col    <= 6'd0;
                                end
                            end
                        end
                    end
                end

                CLR_LINE: begin
                    if (clr_col == 6'(COLS)) begin
                        state   <= IDLE;
                        top_row <= row_inc(top_row);
                    end else begin
                        vram_wen   <= 1'b1;
                        vram_waddr <= addr_of(cursor_row, clr_col);
                        vram_din   <= BLANK;
                        clr_col    <= clr_col + 6'd1;
                    end
                end

                default: state <= CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_term.sv
// Directed bench for vram_term: expected VRAM writes are queued at stimulus
// time and popped as the engine produces them.
module tb_vram_term;

    logic        clk;
    logic        rst;
    logic [6:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        clr_screen;
    logic [10:0] vram_waddr;
    logic [5:0]  vram_din;
    logic        vram_wen;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [4:0]  top_row;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    vram_term dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clr_screen (clr_screen),
        .vram_waddr (vram_waddr),
        .vram_din   (vram_din),
        .vram_wen   (vram_wen),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .top_row    (top_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle and score any write the DUT presents.
    task automatic tick();
        logic [16:0] e;
        @(posedge clk);
        #1;
        if (vram_wen === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0d data %h expected none", vram_waddr, vram_din);
            end else begin
                e = exp_q.pop_front();
                assert ({vram_waddr, vram_din} === e) else begin
                    errors++;
                    $error("FAIL write: observed addr %0d data %h expected addr %0d data %h",
                           vram_waddr, vram_din, e[16:6], e[5:0]);
                end
            end
        end
    endtask

    function automatic logic [5:0] model_code(input logic [6:0] c);
        logic [6:0] f;
        f = (c >= 7'h60) ? c - 7'h20 : c;
        return f[5:0];
    endfunction

    task automatic push_blanks(input int first, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back({11'(first + i), 6'h20});
    endtask

    task automatic send(input logic [6:0] c);
        chk("ready_before_send", int'(char_ready), 1);
        char_valid = 1'b1;
        char_in    = c;
        tick();
        char_valid = 1'b0;
    endtask

    // Print at the current model cursor, queueing the expected write.
    task automatic put(input logic [6:0] c, input int row, input int col);
        exp_q.push_back({11'(row * 40 + col), model_code(c)});
        send(c);
    endtask

    task automatic wait_ready(input int bound, output int n);
        n = 0;
        while (char_ready !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        if (char_ready !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL wait_ready_timeout: observed ready %b after %0d cycles expected 1", char_ready, n);
        end
    endtask

    task automatic chk_cursor(input string tag, input int col, input int row, input int top);
        chk({tag, "_col"}, int'(cursor_col), col);
        chk({tag, "_row"}, int'(cursor_row), row);
        chk({tag, "_top"}, int'(top_row), top);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        char_in    = 7'h00;
        char_valid = 1'b0;
        clr_screen = 1'b0;

        // Reset state and full-screen clear
        tick();
        tick();
        chk("rst_wen", int'(vram_wen), 0);
        chk("rst_addr", int'(vram_waddr), 0);
        chk("rst_din", int'(vram_din), 0);
        chk("rst_ready", int'(char_ready), 0);
        chk_cursor("rst", 0, 0, 0);
        rst = 1'b0;
        push_blanks(0, 960);
        wait_ready(2000, n);
        chk("clr_all_cycles", n, 961);
        chk("clr_all_drained", exp_q.size(), 0);
        chk_cursor("after_clr", 0, 0, 0);

        // Printable and lowercase fold, back-to-back
        put(7'h41, 0, 0);
        put(7'h61, 0, 1);
        chk("fold_drained", exp_q.size(), 0);
        chk_cursor("fold", 2, 0, 0);
        put(7'h42, 0, 2);
        put(7'h63, 0, 3);
        put(7'h5F, 0, 4);
        chk_cursor("col5", 5, 0, 0);

        // CR and ignored control character
        send(7'h0D);
        chk_cursor("cr", 0, 1, 0);
        send(7'h07);
        chk_cursor("bel", 0, 1, 0);
        chk("bel_ready", int'(char_ready), 1);
        tick();
        chk("ctrl_drained", exp_q.size(), 0);

        // Wrap from row 3
        send(7'h0D);
        send(7'h0D);
        chk_cursor("row3", 0, 3, 0);
        for (int c = 0; c < 40; c++) put(7'h58, 3, c);
        chk_cursor("wrap", 0, 4, 0);
        chk("wrap_ready", int'(char_ready), 1);
        tick();
        tick();
        chk("wrap_drained", exp_q.size(), 0);

        // Scroll on CR from the bottom row
        for (int r = 4; r < 23; r++) send(7'h0D);
        chk_cursor("row23", 0, 23, 0);
        push_blanks(0, 40);
        send(7'h0D);
        chk("scroll1_ready_low", int'(char_ready), 0);
        chk("scroll1_top_hold", int'(top_row), 0);
        wait_ready(200, n);
        chk("scroll1_low_cycles", n, 40);
        chk("scroll1_drained", exp_q.size(), 0);
        chk_cursor("scroll1", 0, 0, 1);

        // Second scroll clears physical row 1
        push_blanks(40, 40);
        send(7'h0D);
        wait_ready(200, n);
        chk("scroll2_low_cycles", n, 40);
        chk("scroll2_drained", exp_q.size(), 0);
        chk_cursor("scroll2", 0, 1, 2);

        // Wrapping printable on the bottom row: char write then 40 clears
        for (int c = 0; c < 40; c++) put(7'h7A, 1, c);
        push_blanks(80, 40);
        wait_ready(200, n);
        chk("scroll3_low_cycles", n, 41);
        chk("scroll3_drained", exp_q.size(), 0);
        chk_cursor("scroll3", 0, 2, 3);

        // clr_screen beats char_valid in the same cycle
        clr_screen = 1'b1;
        char_valid = 1'b1;
        char_in    = 7'h51;
        #1;
        chk("clr_prio_ready", int'(char_ready), 0);
        tick();
        clr_screen = 1'b0;
        char_valid = 1'b0;
        chk_cursor("clr_entry", 0, 0, 0);
        chk("clr_entry_wen", int'(vram_wen), 0);

        // Reset while the clear is at address 500
        push_blanks(0, 501);
        for (int i = 0; i < 501; i++) tick();
        chk("mid_clr_addr", int'(vram_waddr), 500);
        chk("mid_drained", exp_q.size(), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_blanks(0, 960);
        wait_ready(2000, n);
        chk("restart_cycles", n, 961);
        chk("restart_drained", exp_q.size(), 0);
        chk_cursor("restart", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
